word_packer: RTL
================

// Module: word_packer
// PURPOSE
//  Initiator side of the Dictionary handshake. Collects 5-bit letter codes from the
//  gesture classifier into a 120-bit word (24 chars x 5 b), pulses the dictionary
//  start, waits for its finish, then presents the corrected word downstream.
//  Sits between the classifier output and the Dictionary block.
// PARAMETERS
//  MAX_LEN   24        max characters per word
//  CHAR_W    5         bits per character code (0 = empty, 1..26 = 'a'..'z')
//  WORD_W    120       MAX_LEN*CHAR_W, width of packed word
//  TIMEOUT   5000000   max cycles in WAIT before abort
// PORTS
//  i_clk          in   1       clock
//  i_rst_n        in   1       synchronous active-low reset
//  i_char_valid   in   1       classifier char strobe
//  i_char         in   5       character code
//  i_backspace    in   1       delete last char (1-cycle pulse)
//  i_end          in   1       end-of-word gesture (1-cycle pulse)
//  o_char_ready   out  1       high when chars/backspace/end are accepted
//  o_dict_start   out  1       1-cycle start pulse to Dictionary
//  o_dict_word    out  120     packed word to Dictionary
//  i_dict_finish  in   1       Dictionary done
//  i_dict_word    in   120     corrected word from Dictionary
//  o_word_valid   out  1       1-cycle strobe, o_word valid
//  o_word         out  120     final word, held until next o_word_valid
//  o_len          out  5       chars currently buffered
//  o_overflow     out  1       sticky: char dropped because buffer full
//  o_timeout      out  1       1-cycle strobe with o_word_valid on WAIT abort
//  o_state        out  2       FSM state
// BEHAVIOUR
//  Reset (i_rst_n==0 at posedge): state=COLLECT, buffer=0, o_len=0, o_word=0, all strobes 0,
//   o_overflow=0. Applies in any state; a pending dictionary run is abandoned.
//  Packing: char k occupies bits [5k+4:5k]; char 0 at [4:0]; unused slots are 0.
//  o_dict_word = buffer, combinational, stable from START through WAIT.
//  FSM (o_state): COLLECT=0, START=1, WAIT=2, DONE=3.
//  COLLECT: o_char_ready=1. Per cycle, in priority order:
//   - i_char_valid, code in 1..26: if o_len<MAX_LEN write slot o_len, o_len++;
//     else drop and set o_overflow. Codes 0 and 27..31 are ignored, no flag.
//   - i_backspace (no i_char_valid): if o_len>0, zero slot o_len-1 and o_len--; else no-op.
//   - i_end: if o_len after this cycle's append >0 -> START. The char strobed in the same
//     cycle is included. If o_len==0 then i_end is ignored.
//   - i_backspace together with i_char_valid: the char wins and the backspace is dropped.
//  START: o_dict_start=1 for exactly this cycle -> WAIT. Clear the WAIT counter.
//  WAIT: o_char_ready=0; inputs are ignored; count cycles.
//   - i_dict_finish=1: latch o_word<=i_dict_word -> DONE.
//   - counter reaches TIMEOUT-1 without finish: o_word<=buffer, set timeout flag -> DONE.
//   - finish on the same cycle as the limit: finish wins, no timeout.
//  DONE (1 cycle): o_word_valid=1; o_timeout=1 only if the timeout flag is set.
//   Clear buffer, o_len and o_overflow -> COLLECT.
//  Latency: i_end to o_dict_start = 1 cycle. i_dict_finish to o_word_valid = 1 cycle.
//  o_dict_start is never reasserted while in WAIT. Dictionary o_finish is sampled only in WAIT.
// TESTING
//  1 Chars 3,9,1 then i_end: o_dict_word[14:0]=15'b00001_01001_00011, rest 0. o_dict_start
//    pulses once, 1 cycle after i_end. Stub finish after 10 cycles with word W, then
//    o_word==W and o_word_valid pulses once.
//  2 Chars 5,6, backspace, char 7, end: o_dict_word[9:0]=10'b00111_00101, o_len=2.
//    Backspace at len 0 leaves the word unchanged.
//  3 Send 25 chars of code 1: o_len=24, o_overflow=1, all 24 slots = 1. Overflow clears
//    after DONE.
//  4 Char 4 with i_end in the same cycle on an empty buffer: word has len 1 with slot 0=4.
//    i_end alone on an empty buffer: no start pulse.
//  5 TIMEOUT=16 and finish never arrives: o_word_valid with o_timeout after 16 WAIT cycles.
//    o_word = the original buffer.
//  6 Reset asserted mid-WAIT: next cycle o_state=0, o_len=0, o_dict_start=0. A later finish
//    is ignored.

Source files
------------

// File: rtl/word_packer.sv
// Packs classifier letter codes into a fixed-width word, runs it through the
// dictionary handshake and presents the corrected (or original on timeout) word.
module word_packer #(
    parameter int unsigned MAX_LEN = 24,
    parameter int unsigned CHAR_W  = 5,
    parameter int unsigned WORD_W  = MAX_LEN * CHAR_W,
    parameter int unsigned TIMEOUT = 5000000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_char_valid,
    input  logic [CHAR_W-1:0] i_char,
    input  logic              i_backspace,
    input  logic              i_end,
    output logic              o_char_ready,
    output logic              o_dict_start,
    output logic [WORD_W-1:0] o_dict_word,
    input  logic              i_dict_finish,
    input  logic [WORD_W-1:0] i_dict_word,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word,
    output logic [4:0]        o_len,
    output logic              o_overflow,
    output logic              o_timeout,
    output logic [1:0]        o_state
);

    localparam int unsigned LEN_W = 5;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  word_buf_q, word_buf_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tflag_q, tflag_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               code_ok;

    assign code_ok = (i_char >= CHAR_W'(1)) && (i_char <= CHAR_W'(26));

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= COLLECT;
            word_buf_q <= '0;
            len_q      <= '0;
            overflow_q <= 1'b0;
            cnt_q      <= '0;
            tflag_q    <= 1'b0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_buf_q <= word_buf_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            tflag_q    <= tflag_d;
            word_q     <= word_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        word_buf_d = word_buf_q;
        len_d      = len_q;
        overflow_d = overflow_q;
        cnt_d      = cnt_q;
        tflag_d    = tflag_q;
        word_d     = word_q;

        case (state_q)
            COLLECT: begin
                // A valid char strobe takes priority over a coincident backspace
                if (i_char_valid) begin
                    if (code_ok) begin
                        if (len_q < LEN_W'(MAX_LEN)) begin
                            for (int k = 0; k < int'(MAX_LEN); k++) begin
                                if (len_q == LEN_W'(k)) begin
                                    word_buf_d[k*CHAR_W +: CHAR_W] = i_char;
                                end
                            end
                            len_d = len_q + LEN_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end else if (i_backspace && (len_q != '0)) begin
                    for (int k = 0; k < int'(MAX_LEN); k++) begin
                        if (len_q == LEN_W'(k + 1)) begin
                            word_buf_d[k*CHAR_W +: CHAR_W] = '0;
                        end
                    end
                    len_d = len_q - LEN_W'(1);
                end
                if (i_end && (len_d != '0)) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                tflag_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (i_dict_finish) begin
                    word_d  = i_dict_word;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    word_d  = word_buf_q;
                    tflag_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                word_buf_d = '0;
                len_d      = '0;
                overflow_d = 1'b0;
                state_d    = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    // Outputs decode straight from registered state
    assign o_char_ready = (state_q == COLLECT);
    assign o_dict_start = (state_q == START);
    assign o_word_valid = (state_q == DONE);
    assign o_timeout    = (state_q == DONE) && tflag_q;
    assign o_dict_word  = word_buf_q;
    assign o_word       = word_q;
    assign o_len        = len_q;
    assign o_overflow   = overflow_q;
    assign o_state      = state_q;

endmodule
